// File: rtl/leitor_caminho.sv
// Path reader: stacks path nodes arriving destination->source and replays them
// source->destination on a valid/ready stream, reporting length and overflow.
module leitor_caminho #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MAX_CAMINHO = 64,
  parameter int PTR_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iniciar_in,
  input  logic                  gma_valid_in,
  input  logic [ADDR_WIDTH-1:0] gma_data_in,
  input  logic                  gma_pronto_in,
  output logic                  cam_valid_out,
  output logic [ADDR_WIDTH-1:0] cam_data_out,
  output logic                  cam_ultimo_out,
  input  logic                  cam_ready_in,
  output logic [PTR_WIDTH-1:0]  cam_tamanho_out,
  output logic                  cam_overflow_out,
  output logic                  cam_ocupado_out
);

  localparam int IDX_W = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
  localparam logic [PTR_WIDTH-1:0] CHEIO = PTR_WIDTH'(MAX_CAMINHO);
  localparam logic [PTR_WIDTH-1:0] UM    = PTR_WIDTH'(1);

  typedef enum logic [1:0] {OCIOSO, CAPTURA, ENVIO} estado_t;

  estado_t                state_q, state_d;
  logic [PTR_WIDTH-1:0]   count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]  data_q, data_d;
  logic                   ultimo_q, ultimo_d;
  logic                   ocup_q;
  logic                   push;
  logic [ADDR_WIDTH-1:0]  mem_q [MAX_CAMINHO];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ultimo_d = ultimo_q;
    push     = 1'b0;
    if (iniciar_in) begin
      state_d  = OCIOSO;
      count_d  = '0;
      ovf_d    = 1'b0;
      valid_d  = 1'b0;
      ultimo_d = 1'b0;
    end else begin
      case (state_q)
        OCIOSO, CAPTURA: begin
          if (gma_valid_in) begin
            state_d = CAPTURA;
            if (count_q == CHEIO) begin
              ovf_d = 1'b1;
            end else begin
              push    = 1'b1;
              count_d = count_q + 1'b1;
            end
          end
          // The transition sees the count including a same-cycle push; the
          // freshly pushed node is not in memory yet, so it is bypassed.
          if (gma_pronto_in) begin
            if (count_d != '0) begin
              state_d  = ENVIO;
              valid_d  = 1'b1;
              data_d   = push ? gma_data_in : mem_q[IDX_W'(count_d - 1'b1)];
              ultimo_d = (count_d == UM);
            end else begin
              state_d = OCIOSO;
            end
          end
        end
        ENVIO: begin
          if (valid_q && cam_ready_in) begin
            count_d = count_q - 1'b1;
            if (count_d == '0) begin
              state_d  = OCIOSO;
              valid_d  = 1'b0;
              ultimo_d = 1'b0;
            end else begin
              data_d   = mem_q[IDX_W'(count_d - 1'b1)];
              ultimo_d = (count_d == UM);
            end
          end
        end
        default: state_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OCIOSO;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ultimo_q <= 1'b0;
      ocup_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ultimo_q <= ultimo_d;
      ocup_q   <= (state_d != OCIOSO);
    end
  end

  // Stack storage carries no reset; its contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[IDX_W'(count_q)] <= gma_data_in;
  end

  assign cam_valid_out    = valid_q;
  assign cam_data_out     = data_q;
  assign cam_ultimo_out   = ultimo_q;
  assign cam_tamanho_out  = count_q;
  assign cam_overflow_out = ovf_q;
  assign cam_ocupado_out  = ocup_q;

endmodule
